// File: rtl/four_bit_parallel_adder.sv
// ---------------------------------------------------------------------------
// four_bit_parallel_adder
//
// Registered ripple-carry adder: {carry, sum} = A + B + carry_in, with a
// signed-overflow flag. The combinational core is a chain of WIDTH one-bit
// full adders. Its result is captured in output registers on the rising edge
// where in_valid is high, so the latency is one clock. A new operand set may
// be presented every cycle. There is no backpressure.
//
// Ports
//   clk        in   1      single clock, rising-edge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      A/B/carry_in carry a new operand set this cycle
//   A          in   WIDTH  addend (unsigned; also read as two's complement)
//   B          in   WIDTH  addend
//   carry_in   in   1      carry into bit 0
//   sum        out  WIDTH  registered low WIDTH bits of A+B+carry_in
//   carry      out  1      registered carry out of the MSB
//   overflow   out  1      registered signed overflow (carry into MSB ^ carry out)
//   out_valid  out  1      sum/carry/overflow were updated on the last edge
// ---------------------------------------------------------------------------
module four_bit_parallel_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             carry_in,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow,
    output logic             out_valid
);

    // Ripple chain: c[i] is the carry into bit i, and c[WIDTH] is the carry out.
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    logic [WIDTH-1:0] sum_d,       sum_q;
    logic             carry_d,     carry_q;
    logic             overflow_d,  overflow_q;
    logic             out_valid_d, out_valid_q;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = carry_in;
        for (int i = 0; i < WIDTH; i++) begin
            s[i]   = A[i] ^ B[i] ^ c[i];
            c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
        end
    end

    // Result registers hold their value when no new operands arrive.
    // out_valid is a one-cycle pulse per accepted operand set.
    always_comb begin
        sum_d       = sum_q;
        carry_d     = carry_q;
        overflow_d  = overflow_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            sum_d      = s;
            carry_d    = c[WIDTH];
            overflow_d = c[WIDTH] ^ c[WIDTH-1];
        end
    end

    // ---- stage boundary: operands -> registered result ----
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q       <= '0;
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign sum       = sum_q;
    assign carry     = carry_q;
    assign overflow  = overflow_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_four_bit_parallel_adder.sv
// ---------------------------------------------------------------------------
// tb_four_bit_parallel_adder
//
// Drives four_bit_parallel_adder with directed cases and $urandom operand
// streams. A behavioural model computes every expected output with integer
// arithmetic, in both unsigned and two's-complement form. A scoreboard keeps
// the model's view of the output registers.
// ---------------------------------------------------------------------------
module tb_four_bit_parallel_adder;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         carry_in;
    logic [W-1:0] sum;
    logic         carry;
    logic         overflow;
    logic         out_valid;

    int n_vec  = 0;
    int n_miss = 0;

    // Model view of the registered outputs
    int m_sum, m_carry, m_ovf, m_vld;

    four_bit_parallel_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .carry_in  (carry_in),
        .sum       (sum),
        .carry     (carry),
        .overflow  (overflow),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // Reference: plain unsigned and signed sums
    task automatic ref_add(input int a, input int b, input int ci,
                           output int rs, output int rc, output int ro);
        int u, sa, sb, ss;
        u  = a + b + ci;
        rs = u % 16;
        rc = (u >= 16) ? 1 : 0;
        sa = (a >= 8) ? a - 16 : a;
        sb = (b >= 8) ? b - 16 : b;
        ss = sa + sb + ci;
        ro = (ss > 7 || ss < -8) ? 1 : 0;
    endtask

    // Apply one cycle of inputs, advance the model, and check all outputs after the edge
    task automatic apply(input string tag, input logic r, input logic v,
                         input int a, input int b, input int ci);
        int rs, rc, ro;
        rst      = r;
        in_valid = v;
        A        = W'(a);
        B        = W'(b);
        carry_in = ci[0];
        @(posedge clk);
        if (r) begin
            m_sum = 0; m_carry = 0; m_ovf = 0; m_vld = 0;
        end else begin
            m_vld = v ? 1 : 0;
            if (v) begin
                ref_add(a, b, ci, rs, rc, ro);
                m_sum = rs; m_carry = rc; m_ovf = ro;
            end
        end
        #1;
        chk({tag, "_sum"},  32'(sum),       32'(m_sum));
        chk({tag, "_cy"},   32'(carry),     32'(m_carry));
        chk({tag, "_ovf"},  32'(overflow),  32'(m_ovf));
        chk({tag, "_vld"},  32'(out_valid), 32'(m_vld));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; carry_in = 1'b0;
        m_sum = 0; m_carry = 0; m_ovf = 0; m_vld = 0;

        // 1. reset discards valid operands
        apply("rst0", 1'b1, 1'b1, 15, 15, 1);
        apply("rst1", 1'b1, 1'b1, 15, 15, 1);
        chk("rst_sum_const", 32'(sum), 32'd0);

        // 2. 5+3 -> 8 with signed overflow
        apply("t2", 1'b0, 1'b1, 5, 3, 0);
        chk("t2_sum_const", 32'(sum), 32'h8);
        chk("t2_ovf_const", 32'(overflow), 32'd1);

        // 3. wrap-around
        apply("t3a", 1'b0, 1'b1, 15, 1, 0);
        chk("t3a_cy_const", 32'({carry, sum}), 32'h10);
        apply("t3b", 1'b0, 1'b1, 15, 15, 1);
        chk("t3b_cy_const", 32'({carry, sum}), 32'h1F);

        // 4. -8 + -8, then hold with in_valid low
        apply("t4a", 1'b0, 1'b1, 8, 8, 0);
        apply("t4b", 1'b0, 1'b0, 1, 1, 0);
        chk("t4b_hold_const", 32'({overflow, carry, sum}), 32'h30);
        apply("t4c", 1'b0, 1'b0, 3, 7, 1);

        // 5. random stream with reset mid-stream
        for (int i = 0; i < 6; i++)
            apply("t5s", 1'b0, 1'b1, int'($urandom_range(15)), int'($urandom_range(15)),
                  int'($urandom_range(1)));
        apply("t5r", 1'b1, 1'b1, int'($urandom_range(15)), int'($urandom_range(15)), 1);
        for (int i = 0; i < 6; i++)
            apply("t5p", 1'b0, 1'b1, int'($urandom_range(15)), int'($urandom_range(15)),
                  int'($urandom_range(1)));

        // random valid gaps
        for (int i = 0; i < 40; i++)
            apply("rnd", 1'b0, 1'($urandom_range(1)), int'($urandom_range(15)),
                  int'($urandom_range(15)), int'($urandom_range(1)));

        // 6. exhaustive sweep, back-to-back
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int ci = 0; ci < 2; ci++)
                    apply("sweep", 1'b0, 1'b1, a, b, ci);

        apply("tail", 1'b0, 1'b0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
